// File: rtl/uart_pkg.sv
// Shared UART byte-packing definitions: FSM state encoding and width constants
// used by both the 24-to-8 serializer and the 8-to-24 packer.
package uart_pkg;

  typedef enum logic [0:0] {TX_IDLE, TX_SEND} tx_state_t;

  localparam int UART_BYTE_W    = 8;
  localparam int UART_CNT_W     = 2;
  localparam int UART_MAX_BYTES = 3;

endpackage

// File: rtl/uart_reg24to8_if.sv
// Word-in / byte-out bundle for uart_reg24to8; master is the FIFO+UART side,
// slave is the serializer.
interface uart_reg24to8_if;
  import uart_pkg::*;

  // Load side: wren is taken only while ready=1. Byte side: a byte moves on
  // every cycle with dout_valid & dout_ready; dout/dout_valid hold until then.
  logic                  wren;
  logic [31:0]           din;
  logic [UART_CNT_W-1:0] valid_bytes;
  logic                  ready;
  logic [UART_BYTE_W-1:0] dout;
  logic                  dout_valid;
  logic                  dout_ready;
  logic [UART_CNT_W-1:0] bytes_left;

  modport master (
    output wren, din, valid_bytes, dout_ready,
    input  ready, dout, dout_valid, bytes_left
  );

  modport slave (
    input  wren, din, valid_bytes, dout_ready,
    output ready, dout, dout_valid, bytes_left
  );

endinterface

// File: rtl/uart_reg24to8.sv
// Serializes up to NUM_BYTES bytes of a loaded word, LSB byte first, onto an
// 8-bit valid/ready stream. UART_REG24TO8_OVERFLOW_EN adds a sticky dropped-load flag.
module uart_reg24to8
  import uart_pkg::*;
#(
  parameter int NUM_BYTES = UART_MAX_BYTES
) (
  input  logic            clk,
  input  logic            rst,
  uart_reg24to8_if.slave  bus,
  output tx_state_t       state
`ifdef UART_REG24TO8_OVERFLOW_EN
  ,
  input  logic            overflow_clr,
  output logic            overflow
`endif
);

  localparam logic [UART_CNT_W-1:0] NB = UART_CNT_W'(NUM_BYTES);

  tx_state_t             state_nxt;
  logic [23:0]           data_q, data_nxt;
  logic [UART_CNT_W-1:0] idx_q, idx_nxt;
  logic [UART_CNT_W-1:0] left_q, left_nxt;
  logic [UART_CNT_W-1:0] eff_cnt;
  logic [UART_BYTE_W-1:0] byte_sel;
  logic                  unused_din_hi;

  assign unused_din_hi = ^bus.din[31:24];
  assign eff_cnt = (bus.valid_bytes > NB) ? NB : bus.valid_bytes;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= TX_IDLE;
      data_q <= '0;
      idx_q  <= '0;
      left_q <= '0;
    end else begin
      state  <= state_nxt;
      data_q <= data_nxt;
      idx_q  <= idx_nxt;
      left_q <= left_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    data_nxt  = data_q;
    idx_nxt   = idx_q;
    left_nxt  = left_q;
    case (state)
      TX_IDLE: begin
        if (bus.wren && (eff_cnt != '0)) begin
          state_nxt = TX_SEND;
          data_nxt  = bus.din[23:0];
          idx_nxt   = '0;
          left_nxt  = eff_cnt;
        end
      end
      TX_SEND: begin
        if (bus.dout_ready) begin
          // Last byte returns idx to 0 so it never walks past NUM_BYTES-1.
          if (left_q == UART_CNT_W'(1)) begin
            state_nxt = TX_IDLE;
            idx_nxt   = '0;
            left_nxt  = '0;
          end else begin
            idx_nxt  = idx_q + UART_CNT_W'(1);
            left_nxt = left_q - UART_CNT_W'(1);
          end
        end
      end
      default: state_nxt = TX_IDLE;
    endcase
  end

  always_comb begin
    case (idx_q)
      2'd0:    byte_sel = data_q[7:0];
      2'd1:    byte_sel = data_q[15:8];
      default: byte_sel = data_q[23:16];
    endcase
  end

  // Outputs depend on registers only; dout reads 0 whenever nothing is offered.
  assign bus.ready      = (state == TX_IDLE);
  assign bus.dout_valid = (state == TX_SEND);
  assign bus.dout       = (state == TX_SEND) ? byte_sel : '0;
  assign bus.bytes_left = left_q;

`ifdef UART_REG24TO8_OVERFLOW_EN
  logic ovf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (bus.wren && (state != TX_IDLE)) begin
      ovf_q <= 1'b1;
    end else if (overflow_clr) begin
      ovf_q <= 1'b0;
    end
  end

  assign overflow = ovf_q;
`endif

endmodule

// File: tb/tb_uart_reg24to8.sv
// Bench for uart_reg24to8: queue-based byte model checked every cycle, directed
// scenarios pinned with literal values, then randomized traffic.
module tb_uart_reg24to8;
  import uart_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_reg24to8_if bus ();
  uart_reg24to8_if bus2 ();
  tx_state_t st, st2;

`ifdef UART_REG24TO8_OVERFLOW_EN
  logic overflow_clr, overflow;
  logic overflow_clr2, overflow2;
`endif

  uart_reg24to8 #(.NUM_BYTES(3)) u_dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .state (st)
`ifdef UART_REG24TO8_OVERFLOW_EN
    ,
    .overflow_clr (overflow_clr),
    .overflow     (overflow)
`endif
  );

  uart_reg24to8 #(.NUM_BYTES(2)) u_dut2 (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus2),
    .state (st2)
`ifdef UART_REG24TO8_OVERFLOW_EN
    ,
    .overflow_clr (overflow_clr2),
    .overflow     (overflow2)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the bytes still owed to the UART, oldest first. Busy == non-empty.
  logic [7:0] exp_q[$];
  bit         ov_exp;
  bit         was_idle;
  int         n_load;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      ov_exp = 1'b0;
    end else begin
      was_idle = (exp_q.size() == 0);
`ifdef UART_REG24TO8_OVERFLOW_EN
      if (bus.wren && !was_idle) ov_exp = 1'b1;
      else if (overflow_clr)     ov_exp = 1'b0;
`endif
      if (!was_idle) begin
        if (bus.dout_ready) void'(exp_q.pop_front());
      end else if (bus.wren) begin
        n_load = (int'(bus.valid_bytes) > 3) ? 3 : int'(bus.valid_bytes);
        for (int k = 0; k < n_load; k++) exp_q.push_back(bus.din[8*k +: 8]);
      end
    end
  end

  // Bytes actually handed over, with bytes_left at the time, for literal pinning.
  logic [7:0] seen_q[$];
  logic [1:0] seen_bl[$];

  always @(negedge clk) begin
    if (!rst) begin
      check("ready",      32'(bus.ready),      32'(exp_q.size() == 0));
      check("dout_valid", 32'(bus.dout_valid), 32'(exp_q.size() != 0));
      check("dout",       32'(bus.dout),       (exp_q.size() != 0) ? 32'(exp_q[0]) : 32'd0);
      check("bytes_left", 32'(bus.bytes_left), 32'(exp_q.size()));
`ifdef UART_REG24TO8_OVERFLOW_EN
      check("overflow",   32'(overflow),       32'(ov_exp));
`endif
      if (bus.dout_valid && bus.dout_ready) begin
        seen_q.push_back(bus.dout);
        seen_bl.push_back(bus.bytes_left);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] d, input logic [1:0] vb);
    bus.wren        = 1'b1;
    bus.din         = d;
    bus.valid_bytes = vb;
    tick();
    bus.wren        = 1'b0;
  endtask

  task automatic expect_seen(input string name, input logic [31:0] b0, input logic [31:0] b1,
                             input logic [31:0] b2, input int n);
    logic [31:0] exp_b[3];
    exp_b[0] = b0; exp_b[1] = b1; exp_b[2] = b2;
    check({name, "_count"}, 32'(seen_q.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (i < seen_q.size()) check({name, "_byte"}, 32'(seen_q[i]), exp_b[i]);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.wren = 1'b0; bus.din = '0; bus.valid_bytes = '0; bus.dout_ready = 1'b1;
    bus2.wren = 1'b0; bus2.din = '0; bus2.valid_bytes = '0; bus2.dout_ready = 1'b1;
`ifdef UART_REG24TO8_OVERFLOW_EN
    overflow_clr = 1'b0; overflow_clr2 = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready",      32'(bus.ready),      32'd1);
    check("rst_dout_valid", 32'(bus.dout_valid), 32'd0);
    check("rst_dout",       32'(bus.dout),       32'd0);
    check("rst_bytes_left", 32'(bus.bytes_left), 32'd0);
    check("rst_state",      32'(st),             32'(TX_IDLE));
    rst = 1'b0;
    tick();

    // Full word, no backpressure
    seen_q.delete(); seen_bl.delete();
    load(32'hFF33_2211, 2'd3);
    repeat (3) tick();
    expect_seen("basic", 32'h11, 32'h22, 32'h33, 3);
    if (seen_bl.size() == 3) begin
      check("basic_bl0", 32'(seen_bl[0]), 32'd3);
      check("basic_bl1", 32'(seen_bl[1]), 32'd2);
      check("basic_bl2", 32'(seen_bl[2]), 32'd1);
    end
    check("basic_ready_after", 32'(bus.ready), 32'd1);

    // Single byte, then an empty load
    seen_q.delete();
    load(32'h0000_00AB, 2'd1);
    tick();
    expect_seen("one_byte", 32'hAB, 32'h0, 32'h0, 1);
    seen_q.delete();
    load(32'h1234_5678, 2'd0);
    check("empty_ready",      32'(bus.ready),      32'd1);
    check("empty_dout_valid", 32'(bus.dout_valid), 32'd0);
    tick();
    check("empty_no_bytes", 32'(seen_q.size()), 32'd0);

    // Backpressure: stall, then alternate ready
    seen_q.delete();
    bus.dout_ready = 1'b0;
    load(32'h00CC_BBAA, 2'd3);
    for (int i = 0; i < 5; i++) begin
      check("stall_dout",  32'(bus.dout),       32'hAA);
      check("stall_valid", 32'(bus.dout_valid), 32'd1);
      tick();
    end
    for (int i = 0; i < 6; i++) begin
      bus.dout_ready = ~bus.dout_ready;
      tick();
    end
    bus.dout_ready = 1'b1;
    repeat (3) tick();
    expect_seen("bp", 32'hAA, 32'hBB, 32'hCC, 3);

    // Load while busy is dropped
    seen_q.delete();
    bus.dout_ready = 1'b0;
    load(32'h0003_0201, 2'd3);
    load(32'h0000_0055, 2'd1);
`ifdef UART_REG24TO8_OVERFLOW_EN
    check("ovf_set", 32'(overflow), 32'd1);
`endif
    bus.dout_ready = 1'b1;
    repeat (5) tick();
    expect_seen("busy", 32'h01, 32'h02, 32'h03, 3);
`ifdef UART_REG24TO8_OVERFLOW_EN
    check("ovf_sticky", 32'(overflow), 32'd1);
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    check("ovf_clr", 32'(overflow), 32'd0);
`endif

    // Asynchronous reset after the first byte
    load(32'h00F3_F2F1, 2'd3);
    tick();
    #3 rst = 1'b1;
    #1;
    check("midrst_valid", 32'(bus.dout_valid), 32'd0);
    check("midrst_left",  32'(bus.bytes_left), 32'd0);
    check("midrst_ready", 32'(bus.ready),      32'd1);
    @(posedge clk);
    #2 rst = 1'b0;
    tick();
    seen_q.delete();
    load(32'h0000_E2E1, 2'd2);
    repeat (2) tick();
    expect_seen("after_rst", 32'hE1, 32'hE2, 32'h0, 2);

    // Two-lane instance: third lane is never emitted
    bus2.wren = 1'b1; bus2.din = 32'h0077_6655; bus2.valid_bytes = 2'd3;
    tick();
    bus2.wren = 1'b0;
    check("nb2_left0", 32'(bus2.bytes_left), 32'd2);
    check("nb2_dout0", 32'(bus2.dout),       32'h55);
    tick();
    check("nb2_left1", 32'(bus2.bytes_left), 32'd1);
    check("nb2_dout1", 32'(bus2.dout),       32'h66);
    tick();
    check("nb2_ready", 32'(bus2.ready),      32'd1);
    check("nb2_valid", 32'(bus2.dout_valid), 32'd0);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      bus.wren        = ($urandom_range(0, 2) == 0);
      bus.din         = $urandom;
      bus.valid_bytes = 2'($urandom_range(0, 3));
      bus.dout_ready  = ($urandom_range(0, 3) != 0);
`ifdef UART_REG24TO8_OVERFLOW_EN
      overflow_clr    = ($urandom_range(0, 7) == 0);
`endif
      tick();
    end
    bus.wren = 1'b0;
    bus.dout_ready = 1'b1;
    repeat (5) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
